rle_encoder_transmitter: RTL and testbench

//  Reads result rows (DATA_WIDTH-bit elements) from RAM, run-length encodes each row MSB-first and streams
//  32-bit packed words to the CPU bus. Mirror of the loading-path decoder: word0 = packet size, word1 = row

---
 rtl/rle_encoder_transmitter_pkg.sv | 31 +++
 rtl/rle_encoder_transmitter_packer.sv | 59 +++++
 rtl/rle_encoder_transmitter.sv | 193 +++++++++++++++++++
 tb/tb_rle_encoder_transmitter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_encoder_transmitter_pkg.sv
// rle_encoder_transmitter_pkg: shared types, constants and helpers for the RLE transmit path.
// Holds the bus width, the FSM state encoding, the fallback packet size, the header word layout
// and the packet-size helpers used by the encoder and its packer.
package rle_encoder_transmitter_pkg;

    localparam int         BUS_WIDTH   = 32;
    localparam logic [5:0] LEGAL_PSIZE = 6'd8;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_P, S_HDR_R, S_FETCH, S_WAIT, S_SCAN, S_ENDR, S_NROW, S_FLUSH, S_DONE
    } state_t;

    // Anything outside {4,8,16,32} falls back to 8-bit packets.
    function automatic logic [5:0] legal_psize(input logic [5:0] p);
        return (p == 6'd4 || p == 6'd8 || p == 6'd16 || p == 6'd32) ? p : LEGAL_PSIZE;
    endfunction

    // Largest run a (p-1)-bit run field can hold: 2^(p-1)-1.
    function automatic logic [30:0] run_max(input logic [5:0] p);
        return 31'h7FFF_FFFF >> (6'd32 - p);
    endfunction

    function automatic logic [BUS_WIDTH-1:0] hdr_psize(input logic [5:0] p);
        return {26'b0, p};
    endfunction

    function automatic logic [BUS_WIDTH-1:0] hdr_rows(input logic [15:0] r);
        return {16'b0, r};
    endfunction

endpackage

// File: rtl/rle_encoder_transmitter_packer.sv
// rle_encoder_transmitter_packer: packs {ind, run} packets MSB-first into 32-bit bus words.
// Ports: CLK/RST clock and sync reset; i_push/i_ind/i_run/i_psize push one packet of i_psize bits;
// i_load/i_word offer a complete word directly (headers); i_ack consumes the offered word;
// o_word/o_valid the offered word, held until acknowledged. The caller must not push while o_valid.
module rle_encoder_transmitter_packer
    import rle_encoder_transmitter_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_push,
    input  logic                 i_ind,
    input  logic [30:0]          i_run,
    input  logic [5:0]           i_psize,
    input  logic                 i_load,
    input  logic [BUS_WIDTH-1:0] i_word,
    input  logic                 i_ack,
    output logic [BUS_WIDTH-1:0] o_word,
    output logic                 o_valid
);

    logic [BUS_WIDTH-1:0] r_acc;
    logic [5:0]           r_fill;
    logic [BUS_WIDTH-1:0] w_pkt;
    logic [BUS_WIDTH-1:0] w_shift;
    logic [6:0]           w_fill;

    always_comb begin
        w_pkt   = ({31'b0, i_ind} << (i_psize - 6'd1)) | {1'b0, i_run};
        w_shift = (r_acc << i_psize) | w_pkt;
        w_fill  = {1'b0, r_fill} + {1'b0, i_psize};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc   <= '0;
            r_fill  <= '0;
            o_word  <= '0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_word  <= i_word;
            o_valid <= 1'b1;
        end else if (o_valid && i_ack) begin
            o_word  <= '0;
            o_valid <= 1'b0;
        end else if (i_push) begin
            // The packet that completes the word moves it straight to the bus register.
            if (w_fill == 7'(BUS_WIDTH)) begin
                o_word  <= w_shift;
                o_valid <= 1'b1;
                r_acc   <= '0;
                r_fill  <= '0;
            end else begin
                r_acc  <= w_shift;
                r_fill <= w_fill[5:0];
            end
        end
    end

endmodule

// File: rtl/rle_encoder_transmitter.sv
// rle_encoder_transmitter: reads result rows from RAM, run-length encodes them MSB-first and streams
// 32-bit words: packet size, row count, then {indication, run} packets padded to a full final word.
// Ports: CLK/RST clock and sync reset; Start/Packet_Size/Row_Count/Row_Length/Start_Address job setup;
// RAM_Read_En/RAM_Address/RAM_Data RAM read port (1-cycle latency); CPU_Bus/Word_Valid/CPU_Ack word
// handshake; Busy job in progress; Done_Sending one-cycle pulse after the last word transfers.
module rle_encoder_transmitter
    import rle_encoder_transmitter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start,
    input  logic [5:0]               Packet_Size,
    input  logic [15:0]              Row_Count,
    input  logic [11:0]              Row_Length,
    input  logic [ADDRESS_WIDTH-1:0] Start_Address,
    output logic                     RAM_Read_En,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address,
    input  logic [DATA_WIDTH-1:0]    RAM_Data,
    output logic [BUS_WIDTH-1:0]     CPU_Bus,
    output logic                     Word_Valid,
    input  logic                     CPU_Ack,
    output logic                     Busy,
    output logic                     Done_Sending
);

    localparam int BW = $clog2(DATA_WIDTH);

    state_t                   r_state;
    logic [5:0]               r_psize;
    logic [15:0]              r_rows;
    logic [11:0]              r_len;
    logic [15:0]              r_row;
    logic [11:0]              r_elem;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [BW-1:0]            r_bit;
    logic [30:0]              r_run;
    logic                     r_cur;
    logic                     r_pend;
    logic                     r_padded;
    logic                     r_ren;
    logic                     r_busy;
    logic                     r_done;

    logic                 w_xfer;
    logic                 w_match;
    logic                 w_sat;
    logic                 w_load;
    logic                 w_push;
    logic                 w_ind;
    logic [30:0]          w_run;
    logic [BUS_WIDTH-1:0] w_word;

    assign RAM_Read_En  = r_ren;
    assign RAM_Address  = r_addr;
    assign Busy         = r_busy;
    assign Done_Sending = r_done;

    always_comb begin
        w_xfer  = Word_Valid && CPU_Ack;
        w_match = r_data[DATA_WIDTH-1] == r_cur;
        w_sat   = r_run == run_max(r_psize);
        w_load  = (r_state == S_IDLE && Start) || (r_state == S_HDR_P && w_xfer);
        w_word  = (r_state == S_IDLE) ? hdr_psize(legal_psize(Packet_Size)) : hdr_rows(r_rows);
        // SCAN emits instead of consuming on a pending zero run, a bit change or a saturated run.
        w_push  = !Word_Valid && ((r_state == S_SCAN && (r_pend || !w_match || w_sat)) ||
                                  r_state == S_ENDR || r_state == S_FLUSH);
        w_ind   = (r_state == S_FLUSH) ? ~r_row[0] : r_row[0];
        w_run   = (r_state == S_FLUSH || r_pend) ? '0 : r_run;
    end

    rle_encoder_transmitter_packer u_packer (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_ind   (w_ind),
        .i_run   (w_run),
        .i_psize (r_psize),
        .i_load  (w_load),
        .i_word  (w_word),
        .i_ack   (CPU_Ack),
        .o_word  (CPU_Bus),
        .o_valid (Word_Valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_psize  <= '0;
            r_rows   <= '0;
            r_len    <= '0;
            r_row    <= '0;
            r_elem   <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_bit    <= '0;
            r_run    <= '0;
            r_cur    <= 1'b0;
            r_pend   <= 1'b0;
            r_padded <= 1'b0;
            r_ren    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (Start) begin
                    r_psize  <= legal_psize(Packet_Size);
                    r_rows   <= Row_Count;
                    r_len    <= Row_Length;
                    r_addr   <= Start_Address;
                    r_row    <= '0;
                    r_elem   <= '0;
                    r_bit    <= '0;
                    r_run    <= '0;
                    // Row r's first run counts bit value ~r[0]; row 0 starts on ones.
                    r_cur    <= 1'b1;
                    r_pend   <= 1'b0;
                    r_padded <= 1'b0;
                    r_busy   <= 1'b1;
                    r_state  <= S_HDR_P;
                end
                S_HDR_P: if (w_xfer) r_state <= S_HDR_R;
                S_HDR_R: if (w_xfer) begin
                    r_ren   <= 1'b1;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_ren   <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_data  <= RAM_Data;
                    r_addr  <= r_addr + ADDRESS_WIDTH'(1);
                    r_state <= S_SCAN;
                end
                S_SCAN: if (!Word_Valid) begin
                    if (r_pend)
                        r_pend <= 1'b0;
                    else if (!w_match) begin
                        r_cur <= ~r_cur;
                        r_run <= '0;
                    end else if (w_sat) begin
                        // Saturated run: M goes out now, the zero-length opposite run next cycle.
                        r_pend <= 1'b1;
                        r_run  <= '0;
                    end else begin
                        r_run  <= r_run + 31'd1;
                        r_data <= r_data << 1;
                        r_bit  <= r_bit + BW'(1);
                        if (r_bit == BW'(DATA_WIDTH - 1)) begin
                            if (r_elem == r_len - 12'd1)
                                r_state <= S_ENDR;
                            else begin
                                r_elem  <= r_elem + 12'd1;
                                r_ren   <= 1'b1;
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end
                S_ENDR: if (!Word_Valid) r_state <= S_NROW;
                // Waiting here keeps the next row's RAM read behind a pending full word.
                S_NROW: if (r_row == r_rows - 16'd1)
                    r_state <= S_FLUSH;
                else if (!Word_Valid) begin
                    r_row   <= r_row + 16'd1;
                    r_cur   <= r_row[0];
                    r_run   <= '0;
                    r_elem  <= '0;
                    r_ren   <= 1'b1;
                    r_state <= S_FETCH;
                end
                // Pad until the word fills; at least one pad even if the last data word was exactly full.
                S_FLUSH: if (!Word_Valid)
                    r_padded <= 1'b1;
                else if (r_padded && CPU_Ack) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_encoder_transmitter.sv
// tb_rle_encoder_transmitter: randomized scoreboard bench against a list-based RLE reference model.
module tb_rle_encoder_transmitter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic [5:0]  Packet_Size = '0;
    logic [15:0] Row_Count = '0;
    logic [11:0] Row_Length = '0;
    logic [12:0] Start_Address = '0;
    logic        RAM_Read_En;
    logic [12:0] RAM_Address;
    logic [63:0] RAM_Data = '0;
    logic [31:0] CPU_Bus;
    logic        Word_Valid;
    logic        CPU_Ack = 1'b0;
    logic        Busy;
    logic        Done_Sending;

    always #5 CLK = ~CLK;

    rle_encoder_transmitter dut (
        .CLK           (CLK),
        .RST           (RST),
        .Start         (Start),
        .Packet_Size   (Packet_Size),
        .Row_Count     (Row_Count),
        .Row_Length    (Row_Length),
        .Start_Address (Start_Address),
        .RAM_Read_En   (RAM_Read_En),
        .RAM_Address   (RAM_Address),
        .RAM_Data      (RAM_Data),
        .CPU_Bus       (CPU_Bus),
        .Word_Valid    (Word_Valid),
        .CPU_Ack       (CPU_Ack),
        .Busy          (Busy),
        .Done_Sending  (Done_Sending)
    );

    logic [63:0] mem [0:8191];
    always @(posedge CLK) if (RAM_Read_En) RAM_Data <= mem[RAM_Address];

    int          total = 0;
    int          bad = 0;
    int          xfers = 0;
    bit          hold = 1'b0;
    logic [31:0] exp_q[$];
    logic [12:0] addr_q[$];
    logic [31:0] pk_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a word transfers on the edge after Valid && Ack are seen here.
    always @(negedge CLK) if (!RST) begin
        if (Word_Valid && CPU_Ack) begin
            xfers++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_word: got %0h expected none", CPU_Bus);
            end else check("word", 64'(CPU_Bus), 64'(exp_q.pop_front()));
        end
        if (RAM_Read_En) begin
            if (addr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_read: got %0h expected none", RAM_Address);
            end else check("ram_addr", 64'(RAM_Address), 64'(addr_q.pop_front()));
        end
    end

    initial forever begin
        @(posedge CLK); #1;
        CPU_Ack = !hold && ($urandom_range(3) != 0);
    end

    function automatic logic [31:0] pkt(input int t, input longint l, input int p);
        return (32'(t) << (p - 1)) | 32'(l);
    endfunction

    // A run longer than M is split as M, 0, M, 0, ..., remainder.
    task automatic emit(input int t, input int len, input longint m, input int p);
        int l = len;
        while (l > m) begin
            pk_q.push_back(pkt(t, m, p));
            pk_q.push_back(pkt(t, 0, p));
            l -= int'(m);
        end
        pk_q.push_back(pkt(t, l, p));
    endtask

    task automatic expect_stream(input int p, input int rows, input int len, input logic [12:0] start);
        longint      m = (64'd1 << (p - 1)) - 1;
        int          slots = 32 / p;
        int          t, cur, l, pads;
        logic [12:0] a = start;
        logic [63:0] e;
        logic [31:0] w;
        exp_q.push_back(32'(p));
        exp_q.push_back(32'(rows));
        pk_q.delete();
        for (int r = 0; r < rows; r++) begin
            t = r % 2;
            cur = 1 - t;
            l = 0;
            for (int el = 0; el < len; el++) begin
                addr_q.push_back(a);
                e = mem[a];
                a = a + 13'd1;
                for (int b = 63; b >= 0; b--) begin
                    if (int'(e[b]) == cur) l++;
                    else begin
                        emit(t, l, m, p);
                        cur = int'(e[b]);
                        l = 1;
                    end
                end
            end
            emit(t, l, m, p);
        end
        pads = slots - (pk_q.size() % slots);
        for (int i = 0; i < pads; i++) pk_q.push_back(pkt(1 - ((rows - 1) % 2), 0, p));
        while (pk_q.size() > 0) begin
            w = '0;
            for (int j = 0; j < slots; j++) w = (w << p) | pk_q.pop_front();
            exp_q.push_back(w);
        end
    endtask

    function automatic logic [63:0] rand_elem();
        logic [63:0] ones = '1;
        case ($urandom_range(3))
            0: return {$urandom, $urandom};
            1: return ones;
            2: return '0;
            default: return ones >> $urandom_range(63);
        endcase
    endfunction

    task automatic fill(input logic [12:0] start, input int n);
        logic [12:0] a = start;
        for (int i = 0; i < n; i++) begin
            mem[a] = rand_elem();
            a = a + 13'd1;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {28'b0, RAM_Read_En, Word_Valid, Busy, Done_Sending, CPU_Bus}, 64'd0);
        check({name, "_addr"}, 64'(RAM_Address), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1;
        check_idle_outputs("reset_outputs");
        RST = 1'b0;
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic run_stream(input int p_in, input int rows, input int len, input logic [12:0] start,
                              input bit stall, input bit busy_start);
        int          p = (p_in == 4 || p_in == 8 || p_in == 16 || p_in == 32) ? p_in : 8;
        int          i;
        bit          got = 1'b0;
        logic [31:0] saved;
        xfers = 0;
        expect_stream(p, rows, len, start);
        @(posedge CLK); #1;
        Packet_Size = 6'(p_in); Row_Count = 16'(rows); Row_Length = 12'(len);
        Start_Address = start; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0; Packet_Size = 6'd16; Row_Count = 16'hFFFF; Row_Length = 12'd7;
        Start_Address = 13'($urandom);
        check("busy_after_start", 64'(Busy), 64'd1);
        if (busy_start) begin
            repeat (6) @(posedge CLK);
            #1 Start = 1'b1;
            @(posedge CLK); #1 Start = 1'b0;
        end
        if (stall) begin
            i = 0;
            while (xfers < 2 && i < 10000) begin @(posedge CLK); #2; i++; end
            hold = 1'b1;
            i = 0;
            do begin @(negedge CLK); i++; end while (!Word_Valid && i < 10000);
            check("stall_word3_seen", 64'(Word_Valid), 64'd1);
            saved = CPU_Bus;
            repeat (20) begin
                @(negedge CLK);
                check("stall_hold", {30'b0, RAM_Read_En, Word_Valid, CPU_Bus}, {31'b0, 1'b1, saved});
            end
            hold = 1'b0;
        end
        for (i = 0; i < 10000; i++) begin
            @(negedge CLK);
            if (Done_Sending) begin got = 1'b1; break; end
        end
        check("done_seen", 64'(got), 64'd1);
        if (got) begin
            check("busy_at_done", 64'(Busy), 64'd0);
            check("words_left", 64'(exp_q.size()), 64'd0);
            check("reads_left", 64'(addr_q.size()), 64'd0);
            @(negedge CLK);
            check("done_pulse_width", 64'(Done_Sending), 64'd0);
        end else pulse_reset();
    endtask

    initial begin
        int i;
        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("reset_outputs");
        RST = 1'b0;

        mem[100] = 64'hFFFF_FFFF_0000_0000;
        run_stream(8, 1, 1, 13'd100, 1'b0, 1'b0);
        mem[200] = 64'h0;
        run_stream(8, 1, 1, 13'd200, 1'b0, 1'b0);
        mem[300] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_stream(4, 1, 1, 13'd300, 1'b0, 1'b0);
        fill(13'd400, 4);
        run_stream(16, 2, 2, 13'd400, 1'b0, 1'b0);
        fill(13'd500, 2);
        run_stream(5, 1, 2, 13'd500, 1'b0, 1'b0);
        fill(13'd600, 6);
        run_stream(32, 3, 2, 13'd600, 1'b0, 1'b0);
        fill(13'h1FFE, 4);
        run_stream(8, 2, 2, 13'h1FFE, 1'b0, 1'b0);
        fill(13'd700, 6);
        run_stream(8, 2, 3, 13'd700, 1'b1, 1'b0);
        fill(13'd800, 2);
        run_stream(4, 1, 2, 13'd800, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            int          p = 4 << $urandom_range(3);
            int          rows = $urandom_range(1, 3);
            int          len = $urandom_range(1, 3);
            logic [12:0] st = 13'($urandom);
            fill(st, rows * len);
            run_stream(p, rows, len, st, 1'b0, 1'b0);
        end

        fill(13'd900, 2);
        expect_stream(16, 1, 2, 13'd900);
        @(posedge CLK); #1;
        Packet_Size = 6'd16; Row_Count = 16'd1; Row_Length = 12'd2; Start_Address = 13'd900; Start = 1'b1;
        @(posedge CLK); #1 Start = 1'b0;
        i = 0;
        do begin @(negedge CLK); i++; end while (!RAM_Read_En && i < 10000);
        check("mid_reset_read_seen", 64'(RAM_Read_En), 64'd1);
        repeat (5) @(posedge CLK);
        pulse_reset();
        run_stream(8, 1, 2, 13'd900, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
